// File: rtl/ahb_rr_interconnect.sv
// Single-layer AHB interconnect: round-robin arbiter with HLOCK and parking, owner-muxed address phase,
// decoder, and data-phase muxes that follow HREADY stalls; unmapped addresses hit a two-cycle ERROR slave.
module ahb_rr_interconnect #(
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 4,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(NUM_MASTERS),
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                          HCLK,
    input  logic                          HRST,
    input  logic [NUM_MASTERS-1:0]        HBUSREQ,
    input  logic [NUM_MASTERS-1:0]        HLOCK,
    input  logic [2*NUM_MASTERS-1:0]      HTRANS,
    input  logic [NUM_MASTERS-1:0]        HWRITE,
    input  logic [3*NUM_MASTERS-1:0]      HSIZE,
    input  logic [3*NUM_MASTERS-1:0]      HBURST,
    input  logic [3*NUM_MASTERS-1:0]      HPROT,
    input  logic [ADDR_W*NUM_MASTERS-1:0] HADDR,
    input  logic [DATA_W*NUM_MASTERS-1:0] HWDATA,
    output logic [NUM_MASTERS-1:0]        HGRANT,
    output logic [MW-1:0]                 HMASTER,
    output logic                          HMASTLOCK,
    output logic                          HREADY,
    output logic                          HRESP,
    output logic [DATA_W-1:0]             HRDATA,
    output logic [NUM_SLAVES-1:0]         HSEL_S,
    output logic [ADDR_W-1:0]             HADDR_S,
    output logic                          HWRITE_S,
    output logic [2:0]                    HSIZE_S,
    output logic [2:0]                    HBURST_S,
    output logic [2:0]                    HPROT_S,
    output logic [1:0]                    HTRANS_S,
    output logic [DATA_W-1:0]             HWDATA_S,
    input  logic [DATA_W*NUM_SLAVES-1:0]  HRDATA_S,
    input  logic [NUM_SLAVES-1:0]         HREADY_S,
    input  logic [NUM_SLAVES-1:0]         HRESP_S
);

    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {DP_IDLE, DP_SLAVE, DP_ERR1, DP_ERR2} dp_state_t;

    logic [MW-1:0]          owner;
    logic [NUM_MASTERS-1:0] grant;
    logic                   mastlock;
    dp_state_t              dp_state;
    logic [MW-1:0]          dp_master;
    logic [SW-1:0]          dp_slave;

    logic [SW-1:0]          slv_idx;
    logic                   addr_active;
    logic                   slv_mapped;
    logic                   hold;
    logic                   rr_found;
    logic [MW-1:0]          rr_next;
    logic [MW-1:0]          cand;
    logic [MW-1:0]          next_owner;
    logic [NUM_MASTERS-1:0] next_grant;

    assign HGRANT    = grant;
    assign HMASTER   = owner;
    assign HMASTLOCK = mastlock;

    always_comb begin
        HADDR_S  = '0;
        HTRANS_S = '0;
        HWRITE_S = 1'b0;
        HSIZE_S  = '0;
        HBURST_S = '0;
        HPROT_S  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (owner == MW'(m)) begin
                HADDR_S  = HADDR[m*ADDR_W +: ADDR_W];
                HTRANS_S = HTRANS[2*m +: 2];
                HWRITE_S = HWRITE[m];
                HSIZE_S  = HSIZE[3*m +: 3];
                HBURST_S = HBURST[3*m +: 3];
                HPROT_S  = HPROT[3*m +: 3];
            end
        end
    end

    assign slv_idx     = HADDR_S[ADDR_W-1 -: SW];
    assign addr_active = (HTRANS_S == TR_NONSEQ) || (HTRANS_S == TR_SEQ);
    assign slv_mapped  = {1'b0, slv_idx} < (SW+1)'(NUM_SLAVES);

    always_comb begin
        HSEL_S = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            HSEL_S[s] = addr_active && (slv_idx == SW'(s));
        end
    end

    // Search starts just after the current owner, so the owner is the last candidate
    // and keeps the bus only when nobody else is asking.
    always_comb begin
        rr_found = 1'b0;
        rr_next  = MW'(DEFAULT_MASTER);
        cand     = owner;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (cand == MW'(NUM_MASTERS-1)) ? '0 : cand + MW'(1);
            if (!rr_found && HBUSREQ[cand]) begin
                rr_found = 1'b1;
                rr_next  = cand;
            end
        end
    end

    assign hold       = (HTRANS_S == TR_SEQ) || (HTRANS_S == TR_BUSY) ||
                        (HLOCK[owner] && HBUSREQ[owner]);
    assign next_owner = hold ? owner : rr_next;

    always_comb begin
        next_grant = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            next_grant[m] = (next_owner == MW'(m));
        end
    end

    always_comb begin
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        HRDATA   = '0;
        HWDATA_S = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (dp_master == MW'(m)) HWDATA_S = HWDATA[m*DATA_W +: DATA_W];
        end
        case (dp_state)
            DP_SLAVE: begin
                for (int s = 0; s < NUM_SLAVES; s++) begin
                    if (dp_slave == SW'(s)) begin
                        HREADY = HREADY_S[s];
                        HRESP  = HRESP_S[s];
                        HRDATA = HRDATA_S[s*DATA_W +: DATA_W];
                    end
                end
            end
            DP_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            DP_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // The first ERROR cycle drives HREADY low itself, so it must advance without waiting on HREADY.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            owner     <= MW'(DEFAULT_MASTER);
            grant     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            mastlock  <= 1'b0;
            dp_state  <= DP_IDLE;
            dp_master <= MW'(DEFAULT_MASTER);
            dp_slave  <= '0;
        end else if (dp_state == DP_ERR1) begin
            dp_state <= DP_ERR2;
        end else if (HREADY) begin
            owner     <= next_owner;
            grant     <= next_grant;
            mastlock  <= HLOCK[next_owner];
            dp_master <= owner;
            if (!addr_active) begin
                dp_state <= DP_IDLE;
            end else if (slv_mapped) begin
                dp_state <= DP_SLAVE;
                dp_slave <= slv_idx;
            end else begin
                dp_state <= DP_ERR1;
            end
        end
    end

endmodule
